// File: rtl/serial_adder_n_if.sv
// rtl/serial_adder_n_if.sv - operand/result handshake bundle for serial_adder_n
interface serial_adder_n_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Adder side: takes operands, produces the result.
  modport slave (
    input  in_valid, a, b, cin, mode, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  // Source/consumer side: offers operands, takes the result.
  modport master (
    output in_valid, a, b, cin, mode, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_n.sv
// rtl/serial_adder_n.sv - digit-serial adder/subtractor, LSB-first, DIGIT bits per clock
module serial_adder_n #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_adder_n_if.slave   bus
);

  if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit
    $fatal(1, "serial_adder_n: DIGIT must lie in 1..WIDTH");
  end else if (WIDTH % DIGIT != 0) begin : g_bad_split
    $fatal(1, "serial_adder_n: WIDTH must be a multiple of DIGIT");
  end

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [DIGIT:0]    slice;
  logic              msb_cin;
  logic [WIDTH-1:0]  res_shift;

  // Ripple slice over the current low digit; carry into the digit MSB is
  // recovered from the sum bit so no second adder is needed for overflow.
  always_comb begin
    slice     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};
    msb_cin   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice[DIGIT-1];
    res_shift = (res_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  // Next-state and datapath: accept, shift one digit per cycle, publish, release.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = S_BUSY;
          a_d     = bus.a;
          b_d     = bus.mode ? ~bus.b : bus.b;
          carry_d = bus.cin ^ bus.mode;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_shift;
        carry_d = slice[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          sum_d   = res_shift;
          cout_d  = slice[DIGIT];
          ovf_d   = slice[DIGIT] ^ msb_cin;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// tb/tb_serial_adder_n.sv - directed and parameter-sweep bench for serial_adder_n
module tb_serial_adder_n;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  bit   sweep_go;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  serial_adder_n_if #(.WIDTH(16)) dif ();
  serial_adder_n #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  task automatic op_start(input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic md);
    @(negedge clk);
    dif.a = a; dif.b = b; dif.cin = ci; dif.mode = md; dif.in_valid = 1'b1;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
  endtask

  task automatic op_wait(input string tag, output int lat);
    lat = 0;
    while (!dif.out_valid && lat < 100) begin
      chk({tag, "_busy_rdy"}, 32'(dif.in_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic op_release(input string tag);
    @(negedge clk);
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    dif.out_ready = 1'b0;
    chk({tag, "_rel_vld"}, 32'(dif.out_valid), 32'd0);
    chk({tag, "_rel_rdy"}, 32'(dif.in_ready), 32'd1);
  endtask

  task automatic run_dir(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic md,
                         input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    op_start(a, b, ci, md);
    op_wait(tag, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_sum"}, 32'(dif.sum), 32'(es));
    chk({tag, "_cout"}, 32'(dif.cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(dif.ovf), 32'(eo));
    op_release(tag);
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int W = (g == 0) ? 16 : (g == 1) ? 16 : (g == 2) ? 8 : 12;
    localparam int D = (g == 0) ? 1  : (g == 1) ? 16 : (g == 2) ? 2 : 3;
    bit done_f;
    serial_adder_n_if #(.WIDTH(W)) sif ();
    serial_adder_n #(.WIDTH(W), .DIGIT(D)) u_sw (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif.slave)
    );

    initial begin
      logic [W-1:0] ra, rb, bb, es;
      logic [W:0]   full;
      logic         ci, md, cc, eo;
      int           lat;
      done_f = 1'b0;
      sif.in_valid = 1'b0; sif.out_ready = 1'b0;
      sif.a = '0; sif.b = '0; sif.cin = 1'b0; sif.mode = 1'b0;
      wait (sweep_go);
      for (int n = 0; n < 12; n++) begin
        ra = W'($urandom);
        rb = W'($urandom);
        ci = 1'($urandom_range(0, 1));
        md = 1'($urandom_range(0, 1));
        bb   = md ? ~rb : rb;
        cc   = md ? ~ci : ci;
        full = {1'b0, ra} + {1'b0, bb} + {{W{1'b0}}, cc};
        es   = full[W-1:0];
        eo   = (ra[W-1] == bb[W-1]) && (es[W-1] != ra[W-1]);
        @(negedge clk);
        sif.a = ra; sif.b = rb; sif.cin = ci; sif.mode = md; sif.in_valid = 1'b1;
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
        lat = 0;
        while (!sif.out_valid && lat < 100) begin
          @(posedge clk);
          #1;
          lat++;
        end
        chk($sformatf("sw%0d_lat", g), 32'(lat), 32'(W / D));
        chk($sformatf("sw%0d_sum", g), 32'(sif.sum), 32'(es));
        chk($sformatf("sw%0d_cout", g), 32'(sif.cout), 32'(full[W]));
        chk($sformatf("sw%0d_ovf", g), 32'(sif.ovf), 32'(eo));
        @(negedge clk);
        sif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        sif.out_ready = 1'b0;
        chk($sformatf("sw%0d_rdy", g), 32'(sif.in_ready), 32'd1);
      end
      done_f = 1'b1;
    end
  end

  initial begin
    int lat;
    int wait_cyc;
    total = 0; bad = 0; sweep_go = 1'b0;
    rst_n = 1'b0;
    dif.in_valid = 1'b0; dif.out_ready = 1'b0;
    dif.a = '0; dif.b = '0; dif.cin = 1'b0; dif.mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(dif.in_ready), 32'd1);
    chk("rst_vld", 32'(dif.out_valid), 32'd0);
    chk("rst_sum", 32'(dif.sum), 32'd0);
    chk("rst_cout", 32'(dif.cout), 32'd0);
    chk("rst_ovf", 32'(dif.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_dir("add0", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_dir("addc", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_dir("addv", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_dir("sub0", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_dir("subv", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_dir("subb", 16'h0003, 16'h0002, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Backpressure: result must hold while the source keeps poking the inputs.
    op_start(16'hF000, 16'h2000, 1'b0, 1'b0);
    op_wait("bp", lat);
    chk("bp_lat", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dif.in_valid = i[0];
      dif.a = 16'($urandom);
      dif.b = 16'($urandom);
      dif.mode = i[1];
      @(posedge clk);
      #1;
      chk("bp_sum", 32'(dif.sum), 32'h1000);
      chk("bp_cout", 32'(dif.cout), 32'd1);
      chk("bp_vld", 32'(dif.out_valid), 32'd1);
      chk("bp_rdy", 32'(dif.in_ready), 32'd0);
    end
    @(negedge clk);
    dif.in_valid = 1'b0;
    op_release("bp");
    @(posedge clk);
    #1;
    chk("bp_idle", 32'(dif.in_ready), 32'd1);

    // Reset two cycles into BUSY must clear everything without a clock edge.
    op_start(16'hABCD, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rdy", 32'(dif.in_ready), 32'd1);
    chk("mid_vld", 32'(dif.out_valid), 32'd0);
    chk("mid_sum", 32'(dif.sum), 32'd0);
    chk("mid_cout", 32'(dif.cout), 32'd0);
    chk("mid_ovf", 32'(dif.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_dir("post", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

    sweep_go = 1'b1;
    wait_cyc = 0;
    while (!(g_sw[0].done_f && g_sw[1].done_f && g_sw[2].done_f && g_sw[3].done_f)
           && wait_cyc < 20000) begin
      @(posedge clk);
      wait_cyc++;
    end
    chk("sweep_done",
        32'({g_sw[3].done_f, g_sw[2].done_f, g_sw[1].done_f, g_sw[0].done_f}), 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
